fc_dot_engine: RTL and testbench

- Downstream consumer of the four-bank activation memory and the FC weight memory.
- Each accepted beat carries 4 signed int8 activations (one byte per bank, bank1 in [31:24]) and 4 matching signed int8 weights.
- Computes a pipelined dot product over a programmed number of beats.
- Presents the 32-bit sum and a requantized int8 result (optional ReLU) on a valid/ready output.

---
 rtl/fc_pkg.sv | 24 ++
 rtl/fc_dot_engine_dot4.sv | 30 +++
 rtl/fc_dot_engine.sv | 91 +++++++++
 tb/tb_fc_dot_engine.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared types, widths, lane helpers and requantization for the FC dot engine
package fc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int ACT_W     = 8;
    localparam int PROD_W    = 16;
    localparam int SUM4_W    = 18;
    localparam int ACC_W     = 32;
    localparam int LANES     = 4;
    localparam int LANE0_MSB = 31;
    localparam logic signed [7:0] Q_MIN = -8'sd128;
    localparam logic signed [7:0] Q_MAX = 8'sd127;
    // Lane 0 sits in the top byte; lane i moves down one byte per index.
    function automatic logic signed [ACT_W-1:0] lane(input logic [31:0] w, input int i);
        return w[LANE0_MSB - ACT_W*i -: ACT_W];
    endfunction
    // Optional ReLU, arithmetic shift, then saturate to int8.
    function automatic logic signed [7:0] requant(input logic signed [ACC_W-1:0] acc,
                                                  input logic [4:0] shift, input logic relu);
        logic signed [ACC_W-1:0] q;
        q = (relu && acc < 0) ? '0 : acc;
        q = q >>> shift;
        return (q < Q_MIN) ? Q_MIN : (q > Q_MAX) ? Q_MAX : q[7:0];
    endfunction
endpackage

// File: rtl/fc_dot_engine_dot4.sv
// dot4_s8: two-stage 4-lane signed int8 multiply and reduce
//   clk, reset (async active-low), valid_in, act/wgt (4 x int8, lane 0 = [31:24])
//   valid_out, sum18 (signed sum of the 4 lane products, two cycles after valid_in)
module dot4_s8
    import fc_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [31:0]              act,
    input  logic [31:0]              wgt,
    output logic                     valid_out,
    output logic signed [SUM4_W-1:0] sum18
);
    logic signed [PROD_W-1:0] prod [LANES];
    logic v1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1        <= 1'b0;
            valid_out <= 1'b0;
            sum18     <= '0;
            for (int i = 0; i < LANES; i++) prod[i] <= '0;
        end else begin
            v1        <= valid_in;
            valid_out <= v1;
            for (int i = 0; i < LANES; i++) prod[i] <= PROD_W'(lane(act, i)) * PROD_W'(lane(wgt, i));
            sum18     <= SUM4_W'(prod[0]) + SUM4_W'(prod[1]) + SUM4_W'(prod[2]) + SUM4_W'(prod[3]);
        end
    end
endmodule

// File: rtl/fc_dot_engine.sv
// fc_dot_engine: pipelined int8 dot product over len_words beats with requantized output
//   clk, reset (async active-low), start/len_words/shift/relu_en (config, sampled on start)
//   in_valid/in_ready/in_act/in_wgt (beat stream), res_valid/res_ready/res_acc/res_q (result), busy
module fc_dot_engine #(
    parameter int LEN_W = 15,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len_words,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    input  logic                    in_valid,
    input  logic [31:0]             in_act,
    input  logic [31:0]             in_wgt,
    output logic                    in_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [ACC_W-1:0] res_acc,
    output logic signed [7:0]       res_q,
    output logic                    busy
);
    import fc_pkg::*;
    state_t state, state_nx;
    logic [LEN_W-1:0] len, cnt;
    logic [4:0] shift_q;
    logic relu_q;
    logic [1:0] dcnt;
    logic signed [ACC_W-1:0] acc;
    logic pv;
    logic signed [SUM4_W-1:0] psum;
    logic hs, last;
    assign in_ready  = (state == RUN);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign hs        = in_valid && in_ready;
    assign last      = hs && (cnt + LEN_W'(1) == len);
    dot4_s8 u_dot4 (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (hs),
        .act       (in_act),
        .wgt       (in_wgt),
        .valid_out (pv),
        .sum18     (psum)
    );
    // DRAIN lasts until the last beat has crossed both product stages and the accumulator.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ((len_words == '0) ? DONE : RUN) : IDLE;
            RUN:     state_nx = last ? DRAIN : RUN;
            DRAIN:   state_nx = (dcnt == 2'd2) ? DONE : DRAIN;
            default: state_nx = res_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            len     <= '0;
            cnt     <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            dcnt    <= '0;
            acc     <= '0;
            res_acc <= '0;
            res_q   <= '0;
        end else begin
            state <= state_nx;
            dcnt  <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
            if (hs) cnt <= cnt + LEN_W'(1);
            if (pv) acc <= acc + ACC_W'(psum);
            if (state == IDLE && start) begin
                len     <= len_words;
                shift_q <= shift;
                relu_q  <= relu_en;
                cnt     <= '0;
                acc     <= '0;
                if (len_words == '0) begin
                    res_acc <= '0;
                    res_q   <= '0;
                end
            end
            if (state == DRAIN && dcnt == 2'd2) begin
                res_acc <= acc;
                res_q   <= requant(acc, shift_q, relu_q);
            end
        end
    end
endmodule

// File: tb/tb_fc_dot_engine.sv
// tb_fc_dot_engine: directed vector table plus handshake, reset and length corner sequences
module tb_fc_dot_engine;
    logic clk = 0, reset = 0, start = 0, relu_en = 0, in_valid = 0, res_ready = 0;
    logic [14:0] len_words = 0;
    logic [4:0] shift = 0;
    logic [31:0] in_act = 0, in_wgt = 0;
    logic in_ready, res_valid, busy;
    logic [31:0] res_acc;
    logic [7:0] res_q;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fc_dot_engine dut (
        .clk(clk), .reset(reset), .start(start), .len_words(len_words), .shift(shift),
        .relu_en(relu_en), .in_valid(in_valid), .in_act(in_act), .in_wgt(in_wgt),
        .in_ready(in_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_acc(res_acc), .res_q(res_q), .busy(busy)
    );

    typedef struct {
        string name;
        int len;
        int sh;
        bit relu;
        logic [31:0] act;
        logic [31:0] wgt;
        longint eacc;
        int eq;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic longint dot4(input logic [31:0] a, input logic [31:0] w);
        longint s = 0;
        for (int i = 0; i < 4; i++) s = s + longint'($signed(a[8*i +: 8])) * longint'($signed(w[8*i +: 8]));
        return s;
    endfunction

    function automatic int rq(input longint v, input int sh, input bit relu);
        longint q = (relu && v < 0) ? 0 : v;
        q = q >>> sh;
        return (q < -128) ? -128 : (q > 127) ? 127 : int'(q);
    endfunction

    task automatic op(input int len, input int sh, input bit relu, input logic [31:0] act,
                      input logic [31:0] wgt, input bit rnd, input bit mid, input bit early,
                      input int hold, input string tag,
                      output longint got_acc, output int got_q, output longint model);
        int beats = 0, cyc = 0, lat = 0;
        logic rdy;
        model = 0;
        res_ready = early;
        len_words = 15'(len);
        shift = 5'(sh);
        relu_en = relu;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        if (len == 0) chk({tag, "_len0_valid"}, 64'(res_valid), 64'(1));
        while (beats < len && cyc < 100000) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_act = rnd ? $urandom : act;
            in_wgt = rnd ? $urandom : wgt;
            start = mid && cyc == 2;
            if (start) len_words = 15'd1;
            rdy = in_ready;
            @(posedge clk); #1;
            start = 0;
            if (in_valid && rdy) begin
                beats++;
                model += dot4(in_act, in_wgt);
            end
            cyc++;
        end
        if (beats < len) chk({tag, "_beats_timeout"}, 64'(beats), 64'(len));
        in_valid = 1;
        in_act = 32'h7f7f7f7f;
        in_wgt = 32'h7f7f7f7f;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 0;
        if (len != 0) chk({tag, "_latency"}, 64'(lat), 64'(3));
        got_acc = longint'($signed(res_acc));
        got_q = int'($signed(res_q));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, {res_valid, res_acc, res_q}, {1'b1, 32'(got_acc), 8'(got_q)});
        end
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        chk({tag, "_after_accept"}, {res_valid, busy}, 2'b00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[9];
        longint a, m;
        int q;
        vt[0] = '{"unit",     1,  0, 0, 32'h01010101, 32'h02020202, 8,      8};
        vt[1] = '{"signed",   1,  8, 0, 32'h807FFF01, 32'h7F80FF01, -32510, -127};
        vt[2] = '{"signed_r", 1,  8, 1, 32'h807FFF01, 32'h7F80FF01, -32510, 0};
        vt[3] = '{"sat0",     4,  0, 0, 32'h7F7F7F7F, 32'h7F7F7F7F, 258064, 127};
        vt[4] = '{"sat11",    4, 11, 0, 32'h7F7F7F7F, 32'h7F7F7F7F, 258064, 126};
        vt[5] = '{"len0",     0,  5, 1, 32'h11111111, 32'h22222222, 0,      0};
        vt[6] = '{"lanes",    3,  2, 0, 32'h01020304, 32'h05060708, 210,    52};
        vt[7] = '{"neg",      2,  1, 0, 32'hFFFFFFFF, 32'h01010101, -8,     -4};
        vt[8] = '{"relu_pos", 2,  0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8,      8};

        @(posedge clk); @(posedge clk); #1;
        chk("por_outputs", {in_ready, res_valid, res_acc, res_q, busy}, '0);
        reset = 1;
        @(posedge clk); #1;
        chk("por_idle", {busy, in_ready, res_valid}, 3'b000);

        for (int i = 0; i < 9; i++) begin
            op(vt[i].len, vt[i].sh, vt[i].relu, vt[i].act, vt[i].wgt, 0, 0, 0, 1, vt[i].name, a, q, m);
            chk({vt[i].name, "_acc"}, 64'(a), 64'(vt[i].eacc));
            chk({vt[i].name, "_q"}, 64'(q), 64'(vt[i].eq));
        end

        op(16, 3, 0, 0, 0, 1, 0, 0, 5, "stress", a, q, m);
        chk("stress_acc", 64'(a), 64'(m));
        chk("stress_q", 64'(q), 64'(rq(m, 3, 0)));

        op(4, 0, 0, 32'h01010101, 32'h01010101, 0, 1, 1, 0, "ign_start", a, q, m);
        chk("ign_start_acc", 64'(a), 64'(16));
        chk("ign_start_q", 64'(q), 64'(16));

        len_words = 15'd8;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        in_valid = 1;
        in_act = 32'h05050505;
        in_wgt = 32'h05050505;
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 0;
        reset = 0;
        #1;
        chk("rst_mid_outputs", {in_ready, res_valid, res_acc, res_q, busy}, '0);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        chk("rst_mid_idle", {busy, res_valid}, 2'b00);
        op(1, 0, 0, 32'h01010101, 32'h02020202, 0, 0, 0, 0, "post_rst", a, q, m);
        chk("post_rst_acc", 64'(a), 64'(8));
        chk("post_rst_q", 64'(q), 64'(8));

        op(16384, 0, 0, 32'h80808080, 32'h80808080, 0, 0, 0, 0, "len_max", a, q, m);
        chk("len_max_acc", 64'(a), 64'(1073741824));
        chk("len_max_q", 64'(q), 64'(127));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
